// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - Sequences one MLP layer through an 8-lane MAC array, group by group.
module mlp_layer_sequencer #(
    parameter logic [2:0] WAITING      = 3'h0,
    parameter logic [2:0] MULTIPLYING  = 3'h1,
    parameter logic [2:0] ACCUMULATING = 3'h2,
    parameter logic [2:0] ACTIVATING   = 3'h3,
    parameter logic [2:0] MULT_WO_ACC  = 3'h4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  n_in,
    input  logic [3:0]  n_grp,
    input  logic [7:0]  shift_cfg,
    output logic        busy,
    output logic        done,
    output logic        ovf_err,
    output logic [7:0]  act_addr,
    input  logic [7:0]  act_rdata,
    output logic [11:0] wgt_addr,
    input  logic [63:0] wgt_rdata,
    output logic [2:0]  step,
    output logic [7:0]  shift,
    output logic [7:0]  A,
    output logic [63:0] B,
    input  logic [63:0] Y,
    input  logic        ovf_in,
    output logic        out_we,
    output logic [3:0]  out_addr,
    output logic [63:0] out_wdata
);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, MAC, ACT, DRN1, DRN2, DONE
    } state_t;

    state_t      state_q;
    logic [7:0]  n_in_q;
    logic [3:0]  n_grp_q;
    logic [7:0]  shift_q;
    logic [7:0]  k_q;
    logic [3:0]  g_q;
    logic [11:0] wgt_q;
    logic [2:0]  step_q;
    logic [7:0]  a_q;
    logic [63:0] b_q;
    logic        busy_q;
    logic        done_q;
    logic        ovf_err_q;
    logic        out_we_q;
    logic        last_k;
    logic        last_g;

    assign last_k = (k_q == n_in_q - 8'd1);
    assign last_g = (g_q == n_grp_q - 4'd1);

    // step_q always carries the command for the state being entered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            n_in_q    <= 8'd0;
            n_grp_q   <= 4'd0;
            shift_q   <= 8'd0;
            k_q       <= 8'd0;
            g_q       <= 4'd0;
            wgt_q     <= 12'd0;
            step_q    <= WAITING;
            a_q       <= 8'd0;
            b_q       <= 64'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_err_q <= 1'b0;
            out_we_q  <= 1'b0;
        end else begin
            step_q   <= WAITING;
            done_q   <= 1'b0;
            out_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (n_in != 8'd0 && n_grp != 4'd0) begin
                            state_q <= FETCH;
                            n_in_q  <= n_in;
                            n_grp_q <= n_grp;
                            shift_q <= shift_cfg;
                            k_q     <= 8'd0;
                            g_q     <= 4'd0;
                            wgt_q   <= 12'd0;
                        end else begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            ovf_err_q <= ovf_in;
                        end
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                    step_q  <= (k_q == 8'd0) ? MULT_WO_ACC : MULTIPLYING;
                end
                LOAD: begin
                    state_q <= MAC;
                    step_q  <= ACCUMULATING;
                    a_q     <= act_rdata;
                    b_q     <= wgt_rdata;
                end
                MAC: begin
                    k_q   <= k_q + 8'd1;
                    wgt_q <= wgt_q + 12'd1;
                    if (last_k) begin
                        state_q <= ACT;
                        step_q  <= ACTIVATING;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                ACT: begin
                    state_q <= DRN1;
                end
                DRN1: begin
                    state_q  <= DRN2;
                    out_we_q <= 1'b1;
                end
                DRN2: begin
                    if (last_g) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        ovf_err_q <= ovf_in;
                    end else begin
                        state_q <= FETCH;
                        k_q     <= 8'd0;
                        g_q     <= g_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf_err   = ovf_err_q;
    assign act_addr  = k_q;
    assign wgt_addr  = wgt_q;
    assign step      = step_q;
    assign shift     = shift_q;
    assign A         = a_q;
    assign B         = b_q;
    assign out_we    = out_we_q;
    assign out_addr  = g_q;
    // The MAC array result is already settled when DRN2 is reached.
    assign out_wdata = out_we_q ? Y : 64'd0;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb/tb_mlp_layer_sequencer.sv - Directed self-checking bench for mlp_layer_sequencer.
module tb_mlp_layer_sequencer;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [7:0]  n_in;
    logic [3:0]  n_grp;
    logic [7:0]  shift_cfg;
    logic        busy;
    logic        done;
    logic        ovf_err;
    logic [7:0]  act_addr;
    logic [7:0]  act_rdata;
    logic [11:0] wgt_addr;
    logic [63:0] wgt_rdata;
    logic [2:0]  step;
    logic [7:0]  shift;
    logic [7:0]  A;
    logic [63:0] B;
    logic [63:0] Y;
    logic        ovf_in;
    logic        out_we;
    logic [3:0]  out_addr;
    logic [63:0] out_wdata;

    mlp_layer_sequencer dut (
        .clk(clk), .resetn(resetn), .start(start), .n_in(n_in), .n_grp(n_grp),
        .shift_cfg(shift_cfg), .busy(busy), .done(done), .ovf_err(ovf_err),
        .act_addr(act_addr), .act_rdata(act_rdata), .wgt_addr(wgt_addr),
        .wgt_rdata(wgt_rdata), .step(step), .shift(shift), .A(A), .B(B), .Y(Y),
        .ovf_in(ovf_in), .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  act_mem [0:255];
    logic [63:0] wgt_mem [0:4095];

    always @(posedge clk) begin
        act_rdata <= act_mem[act_addr];
        wgt_rdata <= wgt_mem[wgt_addr];
    end

    // Behavioral MAC array: acts on the command one cycle after it is issued.
    logic [2:0]         stq;
    logic signed [31:0] acc  [0:7];
    logic signed [31:0] prod [0:7];

    function automatic logic [7:0] relu_sat(input logic signed [31:0] a, input logic [7:0] sh);
        logic signed [31:0] v;
        if (a <= 0) return 8'd0;
        v = a >>> sh;
        if (v > 127) return 8'd127;
        return v[7:0];
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            stq <= 3'd0;
            Y   <= 64'd0;
            for (int j = 0; j < 8; j++) begin
                acc[j]  <= 0;
                prod[j] <= 0;
            end
        end else begin
            stq <= step;
            for (int j = 0; j < 8; j++) begin
                case (stq)
                    3'h4: begin
                        prod[j] <= $signed(A) * $signed(B[8*j +: 8]);
                        acc[j]  <= 0;
                    end
                    3'h1: prod[j] <= $signed(A) * $signed(B[8*j +: 8]);
                    3'h2: acc[j] <= acc[j] + prod[j];
                    3'h3: Y[8*j +: 8] <= relu_sat(acc[j], shift);
                    default: ;
                endcase
            end
        end
    end

    int checks;
    int errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [2:0]  step_tr  [0:1023];
    logic [11:0] wgt_tr   [0:1023];
    logic [7:0]  shift_tr [0:1023];
    int          we_cyc   [0:15];
    logic [3:0]  we_addr  [0:15];
    logic [63:0] we_data  [0:15];
    int          n_we;
    int          done_cyc;
    logic [2:0]  exp_t1   [0:9] = '{3'd0, 3'd4, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd0};

    // Caller is at a negedge (cycle 0); start is sampled at the end of cycle 0.
    task automatic run(input logic [7:0] ni, input logic [3:0] ng, input logic [7:0] sc,
                       input int maxc, input int pulse_at, input int ovf_at);
        n_in = ni;
        n_grp = ng;
        shift_cfg = sc;
        start = 1'b1;
        n_we = 0;
        done_cyc = -1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            start = (c == pulse_at);
            if (c == ovf_at) ovf_in = 1'b1;
            step_tr[c] = step;
            wgt_tr[c] = wgt_addr;
            shift_tr[c] = shift;
            if (out_we) begin
                if (n_we < 16) begin
                    we_cyc[n_we] = c;
                    we_addr[n_we] = out_addr;
                    we_data[n_we] = out_wdata;
                end
                n_we++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_t1(input string tag);
        for (int c = 1; c <= 10; c++)
            check($sformatf("%s_step%0d", tag, c), step_tr[c], exp_t1[c-1]);
        check({tag, "_nwe"}, n_we, 1);
        check({tag, "_we_cyc"}, we_cyc[0], 9);
        check({tag, "_we_addr"}, we_addr[0], 0);
        check({tag, "_wdata"}, we_data[0], {8{8'h50}});
        check({tag, "_done_cyc"}, done_cyc, 10);
        @(negedge clk);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    task automatic load_t2;
        act_mem[0] = 8'd100;
        wgt_mem[0] = 64'h05040302_0100FF64;
    endtask

    initial begin
        int cnt;
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        start = 1'b0;
        n_in = 8'd0;
        n_grp = 4'd0;
        shift_cfg = 8'd0;
        ovf_in = 1'b0;
        for (int i = 0; i < 256; i++) act_mem[i] = 8'd0;
        for (int i = 0; i < 4096; i++) wgt_mem[i] = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {busy, done, out_we, ovf_err}, 4'd0);
        check("rst_step_shift", {step, shift}, 11'd0);
        check("rst_a", A, 8'd0);
        check("rst_b", B, 64'd0);
        check("rst_addr", {act_addr, wgt_addr, out_addr}, 24'd0);
        check("rst_wdata", out_wdata, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        act_mem[0] = 8'd10;
        act_mem[1] = 8'd20;
        wgt_mem[0] = {8{8'h02}};
        wgt_mem[1] = {8{8'h03}};
        run(8'd2, 4'd1, 8'd0, 40, -1, -1);
        check_t1("t1");

        run(8'd2, 4'd1, 8'd0, 40, 4, -1);
        check_t1("busy_start");

        load_t2();
        run(8'd1, 4'd1, 8'd4, 40, -1, -1);
        check("t2_shift", shift_tr[3], 8'd4);
        check("t2_nwe", n_we, 1);
        check("t2_we_cyc", we_cyc[0], 6);
        check("t2_wdata", we_data[0], 64'h1F19120C_0600007F);
        check("t2_done_cyc", done_cyc, 7);
        @(negedge clk);

        act_mem[0] = 8'd10;
        wgt_mem[0] = {8{8'h02}};
        wgt_mem[2] = {8{8'h01}};
        wgt_mem[3] = {8{8'h04}};
        run(8'd2, 4'd2, 8'd0, 60, -1, -1);
        check("t3_wgt0", wgt_tr[1], 12'd0);
        check("t3_wgt1", wgt_tr[4], 12'd1);
        check("t3_wgt2", wgt_tr[10], 12'd2);
        check("t3_wgt3", wgt_tr[13], 12'd3);
        check("t3_nwe", n_we, 2);
        check("t3_we_cyc0", we_cyc[0], 9);
        check("t3_we_cyc1", we_cyc[1], 18);
        check("t3_we_addr0", we_addr[0], 4'd0);
        check("t3_we_addr1", we_addr[1], 4'd1);
        check("t3_wdata0", we_data[0], {8{8'h50}});
        check("t3_wdata1", we_data[1], {8{8'h5A}});
        check("t3_done_cyc", done_cyc, 19);
        @(negedge clk);

        run(8'd0, 4'd1, 8'd0, 10, -1, -1);
        check("nin0_done_cyc", done_cyc, 1);
        check("nin0_nwe", n_we, 0);
        check("nin0_step", step_tr[1], 3'd0);
        @(negedge clk);
        run(8'd2, 4'd0, 8'd0, 10, -1, -1);
        check("ngrp0_done_cyc", done_cyc, 1);
        check("ngrp0_nwe", n_we, 0);
        @(negedge clk);

        run(8'd2, 4'd1, 8'd0, 5, -1, -1);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_ctl", {busy, done, out_we, ovf_err}, 4'd0);
        check("abort_step_shift", {step, shift}, 11'd0);
        check("abort_ab", {A, B[63:8]}, 64'd0);
        check("abort_addr", {act_addr, wgt_addr, out_addr}, 24'd0);
        resetn = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_we || done || busy) cnt++;
        end
        check("abort_quiet", cnt, 0);
        run(8'd2, 4'd1, 8'd0, 40, -1, -1);
        check_t1("restart");

        for (int i = 0; i < 255; i++) begin
            act_mem[i] = 8'd127;
            wgt_mem[i] = {8{8'h7F}};
        end
        run(8'd255, 4'd1, 8'd0, 1000, -1, 100);
        check("ovf_done_cyc", done_cyc, 769);
        check("ovf_wdata", we_data[0], {8{8'h7F}});
        @(negedge clk);
        ovf_in = 1'b0;
        repeat (3) @(negedge clk);
        check("ovf_sticky", ovf_err, 1'b1);
        load_t2();
        run(8'd1, 4'd1, 8'd4, 40, -1, -1);
        check("ovf_clear_done", done_cyc, 7);
        @(negedge clk);
        check("ovf_cleared", ovf_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
